// File: rtl/c499_sec_encoder.sv
// Two-stage streaming SEC encoder producing {data, 8 check bits} for the c499 decoder.
// Optional single-bit error injection is compiled in with `define ECC_ERR_INJECT_EN.
module c499_sec_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             cw_valid,
    input  logic             cw_ready,
    output logic [31:0]      cw_data,
    output logic [7:0]       cw_chk,
    output logic [CNT_W-1:0] enc_count
`ifdef ECC_ERR_INJECT_EN
    ,
    input  logic             inj_en,
    input  logic [5:0]       inj_idx
`endif
);

    function automatic logic [7:0] nibble_parity(input logic [31:0] d);
        logic [7:0] p;
        for (int n = 0; n < 8; n++) begin
            p[n] = ^d[4*n +: 4];
        end
        return p;
    endfunction

    // Lower half folds d0..d15, upper half folds d16..d31, four bits per column.
    function automatic logic [7:0] column_parity(input logic [31:0] d);
        logic [7:0] q;
        for (int j = 0; j < 4; j++) begin
            q[j]     = d[j] ^ d[j+4] ^ d[j+8] ^ d[j+12];
            q[j+4]   = d[j+16] ^ d[j+20] ^ d[j+24] ^ d[j+28];
        end
        return q;
    endfunction

    function automatic logic [7:0] combine_check(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] c;
        c[0] = p[4] ^ p[5] ^ q[0];
        c[1] = p[6] ^ p[7] ^ q[1];
        c[2] = p[4] ^ p[6] ^ q[2];
        c[3] = p[5] ^ p[7] ^ q[3];
        c[4] = p[0] ^ p[1] ^ q[4];
        c[5] = p[2] ^ p[3] ^ q[5];
        c[6] = p[0] ^ p[2] ^ q[6];
        c[7] = p[1] ^ p[3] ^ q[7];
        return c;
    endfunction

    logic             s1_valid_r;
    logic [31:0]      s1_data_r;
    logic [7:0]       s1_p_r;
    logic [7:0]       s1_q_r;
    logic             s2_valid_r;
    logic [31:0]      s2_data_r;
    logic [7:0]       s2_chk_r;
    logic [CNT_W-1:0] count_r;
    logic             s1_inj_en_r;
    logic [5:0]       s1_inj_idx_r;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             in_fire_s;
    logic             s2_fire_s;
    logic             out_fire_s;
    logic [39:0]      flip_s;
    logic [39:0]      next_cw_s;

    // Handshake: each stage advances when empty or when the stage after it advances.
    always_comb begin
        s2_adv_s   = !s2_valid_r || cw_ready;
        s1_adv_s   = !s1_valid_r || s2_adv_s;
        in_fire_s  = in_valid && s1_adv_s;
        s2_fire_s  = s1_valid_r && s2_adv_s;
        out_fire_s = s2_valid_r && cw_ready;
    end

    // Codeword for stage 2, with the optional injected flip applied after check generation.
    always_comb begin
        if (s1_inj_en_r && (s1_inj_idx_r < 6'd40)) begin
            flip_s = 40'd1 << s1_inj_idx_r;
        end else begin
            flip_s = 40'd0;
        end
        next_cw_s = {combine_check(s1_p_r, s1_q_r), s1_data_r} ^ flip_s;
    end

    // Stage-1 valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
        end
    end

    // Stage-1 payload loads only on an accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_r    <= 32'd0;
            s1_p_r       <= 8'd0;
            s1_q_r       <= 8'd0;
            s1_inj_en_r  <= 1'b0;
            s1_inj_idx_r <= 6'd0;
        end else if (in_fire_s) begin
            s1_data_r    <= in_data;
            s1_p_r       <= nibble_parity(in_data);
            s1_q_r       <= column_parity(in_data);
`ifdef ECC_ERR_INJECT_EN
            s1_inj_en_r  <= inj_en;
            s1_inj_idx_r <= inj_idx;
`else
            s1_inj_en_r  <= 1'b0;
            s1_inj_idx_r <= 6'd0;
`endif
        end
    end

    // Stage-2 output registers; payload holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= 32'd0;
            s2_chk_r   <= 8'd0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s2_fire_s) begin
                s2_data_r <= next_cw_s[31:0];
                s2_chk_r  <= next_cw_s[39:32];
            end
        end
    end

    // Count of codewords taken downstream, wrapping silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = s1_adv_s;
    assign cw_valid  = s2_valid_r;
    assign cw_data   = s2_data_r;
    assign cw_chk    = s2_chk_r;
    assign enc_count = count_r;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Randomised self-checking bench for c499_sec_encoder: a queue-based model of the
// in-flight words plus a reference c499 decoder check every output cycle.
module tb_c499_sec_encoder;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'd0;
    logic             cw_valid;
    logic             cw_ready = 1'b0;
    logic [31:0]      cw_data;
    logic [7:0]       cw_chk;
    logic [CNT_W-1:0] enc_count;
`ifdef ECC_ERR_INJECT_EN
    logic             inj_en = 1'b0;
    logic [5:0]       inj_idx = 6'd0;
`endif

    c499_sec_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_chk(cw_chk),
        .enc_count(enc_count)
`ifdef ECC_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_idx(inj_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] cw;
        logic [31:0] data;
        int          acc;
    } ent_t;

    ent_t             sb[$];
    int               n_vec = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               accepted = 0;
    logic [CNT_W-1:0] model_cnt = '0;
    bit               started = 1'b0;
    bit               prev_stall = 1'b0;
    logic [31:0]      prev_data = 32'd0;
    logic [7:0]       prev_chk = 8'd0;

    // Check bits straight from the XOR equations, one mask per check bit.
    function automatic logic [7:0] ref_chk(input logic [31:0] d);
        logic [7:0] c;
        c[0] = ^(d & 32'h00FF_1111);
        c[1] = ^(d & 32'hFF00_2222);
        c[2] = ^(d & 32'h0F0F_4444);
        c[3] = ^(d & 32'hF0F0_8888);
        c[4] = ^(d & 32'h1111_00FF);
        c[5] = ^(d & 32'h2222_FF00);
        c[6] = ^(d & 32'h4444_0F0F);
        c[7] = ^(d & 32'h8888_F0F0);
        return c;
    endfunction

    // c499-style decode: a non-zero syndrome matching a data column flips that bit.
    function automatic logic [31:0] ref_decode(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  s;
        logic [31:0] r;
        logic [31:0] one;
        s = ref_chk(d) ^ c;
        r = d;
        if (s != 8'h00) begin
            for (int i = 0; i < 32; i++) begin
                one = 32'h1 << i;
                if (ref_chk(one) == s) r[i] = ~r[i];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: the model is a queue of words inside the pipe.
    always @(negedge clk) begin : mon
        int          occ;
        bit          exp_v;
        bit          exp_rdy;
        ent_t        e;
        logic [39:0] flip;
        if (rst) begin
            sb.delete();
            model_cnt  = '0;
            started    = 1'b1;
            prev_stall = 1'b0;
        end else if (started) begin
            occ     = sb.size();
            exp_v   = (occ >= 2) || (occ == 1 && cyc >= sb[0].acc + 1);
            exp_rdy = (occ < 2) || cw_ready;
            check("in_ready", in_ready, exp_rdy);
            check("cw_valid", cw_valid, exp_v);
            check("enc_count", enc_count, model_cnt);
            if (prev_stall) begin
                check("hold_data", cw_data, prev_data);
                check("hold_chk", cw_chk, prev_chk);
            end
            if (exp_v && cw_valid) begin
                check("codeword", {cw_chk, cw_data}, sb[0].cw);
                check("decoded", ref_decode(cw_data, cw_chk), sb[0].data);
            end
            prev_stall = exp_v && !cw_ready;
            prev_data  = cw_data;
            prev_chk   = cw_chk;
            if (exp_v && cw_ready) begin
                void'(sb.pop_front());
                model_cnt = model_cnt + 1'b1;
            end
            if (in_valid && exp_rdy) begin
                flip = 40'd0;
`ifdef ECC_ERR_INJECT_EN
                if (inj_en && inj_idx < 6'd40) flip = 40'd1 << inj_idx;
`endif
                e.data = in_data;
                e.cw   = {ref_chk(in_data), in_data} ^ flip;
                e.acc  = cyc + 1;
                sb.push_back(e);
                accepted++;
            end
        end
    end

    task automatic directed(input logic [31:0] d, input logic [7:0] c);
        @(posedge clk); #1 in_valid = 1'b1; in_data = d;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk) check("latency_early", cw_valid, 1'b0);
        @(negedge clk);
        check("latency_t2", cw_valid, 1'b1);
        check("literal_chk", cw_chk, c);
        check("literal_data", cw_data, d);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cw_ready = 1'b1;

        check("model_pin", ref_decode(32'h1234_5658, ref_chk(32'h1234_5678)), 32'h1234_5678);
        directed(32'h0000_0000, 8'h00);
        directed(32'hFFFF_FFFF, 8'h00);
        directed(32'h0000_0001, 8'h51);
        directed(32'h8000_0000, 8'h8A);

        // Three words into a stalled output.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; cw_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001;
        @(posedge clk); #1 in_data = 32'hA5A5_0002;
        @(posedge clk); #1 in_data = 32'hA5A5_0003;
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        check("stall_word1", cw_data, 32'hA5A5_0001);
        repeat (3) @(posedge clk);
        @(negedge clk) check("stall_word1_late", cw_data, 32'hA5A5_0001);
        @(posedge clk); #1 cw_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk) check("stall_count", enc_count, 8'd3);

        // Reset with two words in flight.
        @(posedge clk); #1 cw_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_0001;
        @(posedge clk); #1 in_data = 32'hDEAD_0002;
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; cw_ready = 1'b1;
        @(negedge clk);
        check("rst_cw_valid", cw_valid, 1'b0);
        check("rst_enc_count", enc_count, 8'd0);
        check("rst_in_ready", in_ready, 1'b1);
        repeat (5) @(posedge clk);

`ifdef ECC_ERR_INJECT_EN
        @(posedge clk); #1 in_valid = 1'b1; in_data = 32'h1234_5678; inj_en = 1'b1; inj_idx = 6'd5;
        @(posedge clk); #1 in_valid = 1'b0; inj_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("inj_data", cw_data, 32'h1234_5658);
        check("inj_chk", cw_chk, ref_chk(32'h1234_5678));
        check("inj_decode", ref_decode(cw_data, cw_chk), 32'h1234_5678);
        repeat (3) @(posedge clk);
`endif

        // Random traffic with random downstream stalls.
        accepted = 0;
        guard = 0;
        while (accepted < 1000 && guard < 20000) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            cw_ready = ($urandom_range(0, 2) != 0);
`ifdef ECC_ERR_INJECT_EN
            inj_en  = ($urandom_range(0, 7) == 0);
            inj_idx = 6'($urandom_range(0, 63));
`endif
            guard++;
        end
        check("random_accepted", (accepted >= 1000), 1'b1);
        in_valid = 1'b0;
        cw_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk) check("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
